// File: rtl/pwm_dac_multi_pkg.sv
// Shared types and helpers for the multi-channel PWM DAC.
package pwm_dac_multi_pkg;

  // Pulse alignment, latched once per window.
  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } pwm_mode_e;

  // Clamp a code to the window length so a code above W reads as full-on.
  function automatic logic [31:0] sat_code(input logic [31:0] code, input logic [31:0] limit);
    return (code > limit) ? limit : code;
  endfunction

  // Leading edge of a centre-aligned pulse: floor((W - c) / 2).
  function automatic logic [31:0] center_lo(input logic [31:0] code, input logic [31:0] window);
    return (window - code) >> 1;
  endfunction

endpackage

// File: rtl/pwm_dac_multi_if.sv
// Sample-source side of the PWM DAC: run control, codes, request strobe and outputs.
interface pwm_dac_multi_if #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned CODE_WIDTH = 11
);
  logic                         enable;
  logic                         mode;
  logic [NUM_CH*CODE_WIDTH-1:0] code;
  logic                         next_sample;
  logic [NUM_CH-1:0]            pwm;

  // Sample source / pin consumer.
  modport master (
    output enable,
    output mode,
    output code,
    input  next_sample,
    input  pwm
  );

  // The DAC itself.
  modport slave (
    input  enable,
    input  mode,
    input  code,
    output next_sample,
    output pwm
  );
endinterface

// File: rtl/pwm_dac_channel.sv
// One PWM channel: latches its code as a pair of pulse bounds at the window
// boundary and drives a registered output from the shared window position.
module pwm_dac_channel
  import pwm_dac_multi_pkg::*;
#(
  parameter int unsigned CYCLES_PER_WINDOW = 1024,
  parameter int unsigned CODE_WIDTH        = $clog2(CYCLES_PER_WINDOW) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  latch_i,  // window boundary edge
  input  logic                  run_i,    // position on count_i is live
  input  pwm_mode_e             mode_i,   // alignment in effect for the next window
  input  logic [CODE_WIDTH-1:0] code_i,
  input  logic [CODE_WIDTH-1:0] count_i,
  output logic                  pwm_o
);

  logic [CODE_WIDTH-1:0] code_sat;
  logic [CODE_WIDTH-1:0] lo_d, hi_d;
  logic [CODE_WIDTH-1:0] lo_q, hi_q;
  logic                  pwm_q;

  // Bounds for the incoming code; hi - lo always equals the saturated code.
  always_comb begin
    code_sat = CODE_WIDTH'(sat_code(32'(code_i), 32'(CYCLES_PER_WINDOW)));
    if (mode_i == MODE_CENTER) begin
      lo_d = CODE_WIDTH'(center_lo(32'(code_sat), 32'(CYCLES_PER_WINDOW)));
    end else begin
      lo_d = '0;
    end
    hi_d = lo_d + code_sat;
  end

  // Bound latch and output comparator; the comparison at the boundary edge
  // still uses the old bounds so a full-on channel never dips.
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q  <= '0;
      hi_q  <= '0;
      pwm_q <= 1'b0;
    end else begin
      if (latch_i) begin
        lo_q <= lo_d;
        hi_q <= hi_d;
      end
      pwm_q <= run_i && (count_i >= lo_q) && (count_i < hi_q);
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_dac_multi.sv
// Multi-channel PWM DAC: shared window counter, sample-request strobe, mode
// latch and run control; per-channel bounds and outputs live in pwm_dac_channel.
module pwm_dac_multi
  import pwm_dac_multi_pkg::*;
#(
  parameter int unsigned NUM_CH            = 2,
  parameter int unsigned CYCLES_PER_WINDOW = 1024,
  parameter int unsigned CODE_WIDTH        = $clog2(CYCLES_PER_WINDOW) + 1
) (
  input logic            clk,
  input logic            rst,
  pwm_dac_multi_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(CYCLES_PER_WINDOW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_REQ  = CNT_W'(CYCLES_PER_WINDOW - 2);

  logic [CNT_W-1:0]             count_q, count_d;
  logic                         next_sample_q;
  logic                         en_q;
  pwm_mode_e                    mode_q, mode_d;
  logic                         latch;
  logic                         run;
  logic [CODE_WIDTH-1:0]        count_ext;
  logic [NUM_CH*CODE_WIDTH-1:0] code_vec;
  logic [NUM_CH-1:0]            pwm_vec;

  // Counter advance, boundary detect and the mode that the next window will use.
  always_comb begin
    if (!bus.enable) begin
      count_d = '0;
    end else if (count_q == CNT_LAST) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
    // A boundary latch still happens if enable drops during the last cycle.
    latch  = (count_q == CNT_LAST);
    mode_d = latch ? pwm_mode_e'(bus.mode) : mode_q;
  end

  // Window counter, request strobe, mode latch and delayed enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q       <= '0;
      next_sample_q <= 1'b0;
      mode_q        <= MODE_EDGE;
      en_q          <= 1'b0;
    end else begin
      count_q       <= count_d;
      next_sample_q <= bus.enable && (count_d == CNT_REQ);
      mode_q        <= mode_d;
      en_q          <= bus.enable;
    end
  end

  // The position held in count_q is live if enable was high when it was
  // reached or while it is held; the first forced-zero cycle after a stop is not.
  assign run       = bus.enable | en_q;
  assign count_ext = CODE_WIDTH'(count_q);
  assign code_vec  = bus.code;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_dac_channel #(
      .CYCLES_PER_WINDOW (CYCLES_PER_WINDOW),
      .CODE_WIDTH        (CODE_WIDTH)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .latch_i (latch),
      .run_i   (run),
      .mode_i  (mode_d),
      .code_i  (code_vec[i*CODE_WIDTH +: CODE_WIDTH]),
      .count_i (count_ext),
      .pwm_o   (pwm_vec[i])
    );
  end

  assign bus.next_sample = next_sample_q;
  assign bus.pwm         = pwm_vec;

endmodule
